frame_seq_ctrl: RTL and testbench
=================================

# frame_seq_ctrl

Sequencing controller for the APU frame counter (SoftCLK) LFSR. It takes the counter's step-boundary pulses and register-port events, and from them generates the quarter-frame and half-frame clock pulses, the frame IRQ level, and the counter-clear strobe. It also owns the $4017 mode/inhibit state and its write-to-effect reset delay. It sits between the register decoder and the SoftCLK step decoder, and the envelope, length and sweep units consume its outputs.

## Interface
Parameters:
- DLY_EVEN, 3, cycles from a $4017 write to `cnt_clr` when the write lands with `aclk_odd`=0
- DLY_ODD, 4, the same delay when `aclk_odd`=1

Ports:
- CLK  in  1  CPU-cycle clock, single clock domain
- RES  in  1  reset, asynchronous, active-high
- wr_4017  in  1  one-cycle pulse; $4017 write strobe
- din  in  2  {D7,D6} of the write: [1]=mode (1 = 5-step), [0]=IRQ inhibit
- aclk_odd  in  1  APU half-cycle phase of the current CPU cycle
- rd_4015  in  1  one-cycle pulse; $4015 read, which acknowledges the frame IRQ
- step_hit  in  5  one-hot pulses from the LFSR decoder; bit n = step n reached
- mode  out  1  latched $4017[7]
- irq_inh  out  1  latched $4017[6]
- qframe  out  1  quarter-frame clock pulse
- hframe  out  1  half-frame clock pulse
- frame_irq  out  1  frame interrupt level, active-high
- cnt_clr  out  1  one-cycle pulse that clears the SoftCLK LFSR

## Operation
- **Reset:** `mode`=0, `irq_inh`=0, `qframe`=`hframe`=`cnt_clr`=0, `frame_irq`=0, delay counter idle. RES mid-delay cancels the pending clear.
- **$4017 write:** `mode`/`irq_inh` load from `din` at the write edge. The delay counter loads DLY_EVEN or DLY_ODD according to `aclk_odd` sampled in the write cycle. If `din[0]`=1, `frame_irq` clears.
- **Delay expiry:** one-cycle `cnt_clr`. If `mode`=1 at expiry, `qframe` and `hframe` also pulse in that same cycle (immediate clock).
- **Write while a clear is pending:** the delay restarts from the new phase with the new values. Only one `cnt_clr` is issued, for the last write.
- **Mode 0 (4-step):**
  - step0 → Q
  - step1 → Q+H
  - step2 → Q
  - step3 → Q+H, plus `cnt_clr`; also sets `frame_irq` if `irq_inh`=0
  - step4 is ignored
- **Mode 1 (5-step):**
  - step0 → Q
  - step1 → Q+H
  - step2 → Q
  - step3 → nothing
  - step4 → Q+H, plus `cnt_clr`
  - never sets the IRQ
- **Collision:** a step pulse in the same cycle as delay expiry is discarded. The expiry actions alone apply.
- **`frame_irq`:** a level that holds until `rd_4015`, a write with `din[0]`=1, or RES. If set and `rd_4015` clear occur in the same cycle, set wins.
- **Multi-hot `step_hit`:** an illegal input. The lowest-index set bit is honoured.

## Timing
- All outputs are registered, with 1-cycle latency from the causing input edge.
- `mode`/`irq_inh` are visible in cycle t+1 after a write sampled at edge t.
- Write at edge t with `aclk_odd`=0 → `cnt_clr` high in cycle t+DLY_EVEN. With `aclk_odd`=1 → cycle t+DLY_ODD.
- `qframe`, `hframe` and `cnt_clr` are exactly one cycle wide.
- `frame_irq` rises one cycle after the step3 pulse and falls one cycle after the clearing event.

## Structure
- Package `apu_frame_pkg`:
  - step index constants STEP0..STEP4
  - DLY_EVEN/DLY_ODD defaults
  - mode encoding MODE_4STEP=0 / MODE_5STEP=1
- Sub-module `frame_wr_delay`:
  - 3-bit down-counter with load, restart and RES
  - emits an `expire` pulse
  - the top level holds the step decode, IRQ flag and output registers

## Test plan
- **Reset and write delay:** assert RES while a write delay is pending. All outputs go to 0 immediately and no `cnt_clr` ever follows. Then write `din`=2'b00 with `aclk_odd`=0. Expect `cnt_clr` exactly 3 cycles later and no Q/H pulse. Repeat with `aclk_odd`=1: expect 4 cycles.
- **Mode-1 immediate clock:** write `din`=2'b10. At expiry `cnt_clr`, `qframe` and `hframe` are all high in one cycle. Then pulse step0..step4 in turn: expect Q pulses on 0, 1, 2, 4; H on 1, 4; nothing on 3; `cnt_clr` after step4; `frame_irq` stays 0.
- **Mode-0 IRQ:** `din`=2'b00, then step3. Expect `frame_irq`=1 on the next cycle and held. `rd_4015` → 0 one cycle later. Repeat with step3 and `rd_4015` in the same cycle: `frame_irq` stays 1.
- **Inhibit:** with `frame_irq`=1, write `din`=2'b01. `frame_irq` clears next cycle, and a later step3 does not set it.
- **Double write:** write, then write again 2 cycles later (the first pending delay restarts). Exactly one `cnt_clr`, timed from the second write. Also, a step1 coincident with expiry in mode 0 produces no Q/H.

Source files
------------

// File: rtl/frame_seq_ctrl_pkg.sv
// Shared constants and types for the APU frame sequencing controller.
package apu_frame_pkg;

  localparam int unsigned STEP0 = 0;
  localparam int unsigned STEP1 = 1;
  localparam int unsigned STEP2 = 2;
  localparam int unsigned STEP3 = 3;
  localparam int unsigned STEP4 = 4;

  localparam int unsigned DLY_EVEN_DEF = 3;
  localparam int unsigned DLY_ODD_DEF  = 4;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// Register-port events, step pulses and frame clock outputs of the frame sequencer.
interface frame_seq_ctrl_if;
  logic       wr_4017;
  logic [1:0] din;
  logic       aclk_odd;
  logic       rd_4015;
  logic [4:0] step_hit;
  logic       mode;
  logic       irq_inh;
  logic       qframe;
  logic       hframe;
  logic       frame_irq;
  logic       cnt_clr;

  modport master (
    output wr_4017, din, aclk_odd, rd_4015, step_hit,
    input  mode, irq_inh, qframe, hframe, frame_irq, cnt_clr
  );

  modport slave (
    input  wr_4017, din, aclk_odd, rd_4015, step_hit,
    output mode, irq_inh, qframe, hframe, frame_irq, cnt_clr
  );
endinterface

// File: rtl/frame_wr_delay.sv
// Write-to-clear delay: reloads on every $4017 write, flags the cycle before the clear.
module frame_wr_delay import apu_frame_pkg::*; #(
  parameter int unsigned DLY_EVEN = DLY_EVEN_DEF,
  parameter int unsigned DLY_ODD  = DLY_ODD_DEF
) (
  input  logic CLK,
  input  logic RES,
  input  logic load,
  input  logic odd,
  output logic expire
);

  logic [2:0] cnt;

  // Count runs DLY-1 .. 1; expire at 1 lets the top register cnt_clr in cycle t+DLY.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= odd ? 3'(DLY_ODD - 1) : 3'(DLY_EVEN - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // A write in the expiry cycle restarts the delay and suppresses this clear.
  assign expire = (cnt == 3'd1) && !load;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: step decode, frame IRQ flag, $4017 state and registered clock pulses.
module frame_seq_ctrl import apu_frame_pkg::*; #(
  parameter int unsigned DLY_EVEN = DLY_EVEN_DEF,
  parameter int unsigned DLY_ODD  = DLY_ODD_DEF
) (
  input logic           CLK,
  input logic           RES,
  frame_seq_ctrl_if.slave bus
);

  mode_e      mode_q;
  logic       inh_q;
  logic       q_q, h_q, clr_q, irq_q;
  logic       expire;
  logic [4:0] low;
  logic       q_d, h_d, clr_d, irq_set;

  frame_wr_delay #(
    .DLY_EVEN(DLY_EVEN),
    .DLY_ODD (DLY_ODD)
  ) u_delay (
    .CLK   (CLK),
    .RES   (RES),
    .load  (bus.wr_4017),
    .odd   (bus.aclk_odd),
    .expire(expire)
  );

  // Isolate the lowest set bit so multi-hot inputs honour the earliest step.
  assign low = bus.step_hit & (~bus.step_hit + 5'd1);

  always_comb begin
    q_d     = 1'b0;
    h_d     = 1'b0;
    clr_d   = 1'b0;
    irq_set = 1'b0;
    if (expire) begin
      clr_d = 1'b1;
      q_d   = (mode_q == MODE_5STEP);
      h_d   = (mode_q == MODE_5STEP);
    end else if (low[STEP0] || low[STEP2]) begin
      q_d = 1'b1;
    end else if (low[STEP1]) begin
      q_d = 1'b1;
      h_d = 1'b1;
    end else if (low[STEP3] && mode_q == MODE_4STEP) begin
      q_d     = 1'b1;
      h_d     = 1'b1;
      clr_d   = 1'b1;
      irq_set = !inh_q;
    end else if (low[STEP4] && mode_q == MODE_5STEP) begin
      q_d   = 1'b1;
      h_d   = 1'b1;
      clr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      mode_q <= MODE_4STEP;
      inh_q  <= 1'b0;
      q_q    <= 1'b0;
      h_q    <= 1'b0;
      clr_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      h_q   <= h_d;
      clr_q <= clr_d;
      if (bus.wr_4017) begin
        mode_q <= mode_e'(bus.din[1]);
        inh_q  <= bus.din[0];
      end
      if (bus.wr_4017 && bus.din[0]) begin
        irq_q <= 1'b0;
      end else if (irq_set) begin
        irq_q <= 1'b1;
      end else if (bus.rd_4015) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.mode      = mode_q;
  assign bus.irq_inh   = inh_q;
  assign bus.qframe    = q_q;
  assign bus.hframe    = h_q;
  assign bus.frame_irq = irq_q;
  assign bus.cnt_clr   = clr_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Self-checking bench for frame_seq_ctrl: directed scenarios plus a randomized run against a deadline-based model.
module tb_frame_seq_ctrl;

  localparam int unsigned DLY_E = 3;
  localparam int unsigned DLY_O = 4;

  logic clk;
  logic rst;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  frame_seq_ctrl_if bus ();

  frame_seq_ctrl #(
    .DLY_EVEN(DLY_E),
    .DLY_ODD (DLY_O)
  ) dut (
    .CLK(clk),
    .RES(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mode, irq_inh, qframe, hframe, frame_irq, cnt_clr}
  function automatic logic [5:0] outs();
    return {bus.mode, bus.irq_inh, bus.qframe, bus.hframe, bus.frame_irq, bus.cnt_clr};
  endfunction

  task automatic cyc(input bit w, input bit [1:0] d, input bit o, input bit r, input bit [4:0] st);
    bus.wr_4017  = w;
    bus.din      = d;
    bus.aclk_odd = o;
    bus.rd_4015  = r;
    bus.step_hit = st;
    @(posedge clk);
    #1;
    bus.wr_4017  = 1'b0;
    bus.rd_4015  = 1'b0;
    bus.step_hit = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (outs() !== 6'b000000) $display("FAIL reset_state: got %b expected %b", outs(), 6'b000000);
    else pass_cnt++;
    rst = 1'b0;
    cyc(1, 2'b11, 0, 0, 5'd0);
    chk_cnt++;
    if (outs() !== 6'b110000) $display("FAIL mode_load: got %b expected %b", outs(), 6'b110000);
    else pass_cnt++;
    cyc(0, 2'b00, 0, 0, 5'd0);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (outs() !== 6'b000000) $display("FAIL async_reset: got %b expected %b", outs(), 6'b000000);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 2'b00, 0, 0, 5'd0);
      chk_cnt++;
      if (bus.cnt_clr !== 1'b0) $display("FAIL no_clr_after_reset: cycle %0d got %b expected 0", i, bus.cnt_clr);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_delay();
    for (int o = 0; o < 2; o++) begin
      int unsigned dly;
      logic [5:0]  e;
      dly = (o == 1) ? DLY_O : DLY_E;
      cyc(1, 2'b00, 1'(o), 0, 5'd0);
      for (int unsigned i = 1; i <= 6; i++) begin
        if (i > 1) cyc(0, 2'b00, 0, 0, 5'd0);
        e = {5'b00000, i == dly};
        chk_cnt++;
        if (outs() !== e) $display("FAIL write_delay odd=%0d cycle %0d: got %b expected %b", o, i, outs(), e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mode1();
    logic [5:0] e;
    cyc(1, 2'b10, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'd0);
    chk_cnt++;
    if (outs() !== 6'b101101) $display("FAIL mode1_immediate: got %b expected %b", outs(), 6'b101101);
    else pass_cnt++;
    for (int n = 0; n < 5; n++) begin
      cyc(0, 2'b00, 0, 0, 5'(1 << n));
      e = {1'b1, 1'b0, n != 3, (n == 1) || (n == 4), 1'b0, n == 4};
      chk_cnt++;
      if (outs() !== e) $display("FAIL mode1_step%0d: got %b expected %b", n, outs(), e);
      else pass_cnt++;
      cyc(0, 2'b00, 0, 0, 5'd0);
      chk_cnt++;
      if (outs() !== 6'b100000) $display("FAIL mode1_gap%0d: got %b expected %b", n, outs(), 6'b100000);
      else pass_cnt++;
    end
  endtask

  task automatic test_mode0_irq();
    logic [5:0] obs [6];
    logic [5:0] req [6];
    cyc(1, 2'b00, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'd0);
    chk_cnt++;
    if (bus.cnt_clr !== 1'b1) $display("FAIL mode0_write_clr: got %b expected 1", bus.cnt_clr);
    else pass_cnt++;
    req = '{6'b001111, 6'b000010, 6'b000010, 6'b000000, 6'b001111, 6'b000010};
    cyc(0, 2'b00, 0, 0, 5'b01000); obs[0] = outs();
    cyc(0, 2'b00, 0, 0, 5'd0);     obs[1] = outs();
    cyc(0, 2'b00, 0, 0, 5'd0);     obs[2] = outs();
    cyc(0, 2'b00, 0, 1, 5'd0);     obs[3] = outs();
    cyc(0, 2'b00, 0, 1, 5'b01000); obs[4] = outs();
    cyc(0, 2'b00, 0, 0, 5'd0);     obs[5] = outs();
    for (int i = 0; i < 6; i++) begin
      chk_cnt++;
      if (obs[i] !== req[i]) $display("FAIL mode0_irq[%0d]: got %b expected %b", i, obs[i], req[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_inhibit();
    logic [5:0] e;
    cyc(1, 2'b01, 1, 0, 5'd0);
    chk_cnt++;
    if (outs() !== 6'b010000) $display("FAIL inhibit_clear: got %b expected %b", outs(), 6'b010000);
    else pass_cnt++;
    for (int i = 2; i <= 4; i++) begin
      cyc(0, 2'b00, 0, 0, 5'd0);
      e = {5'b01000, i == 4};
      chk_cnt++;
      if (outs() !== e) $display("FAIL inhibit_delay cycle %0d: got %b expected %b", i, outs(), e);
      else pass_cnt++;
    end
    cyc(0, 2'b00, 0, 0, 5'b01000);
    chk_cnt++;
    if (outs() !== 6'b011101) $display("FAIL inhibit_step3: got %b expected %b", outs(), 6'b011101);
    else pass_cnt++;
    cyc(0, 2'b00, 0, 0, 5'd0);
    chk_cnt++;
    if (outs() !== 6'b010000) $display("FAIL inhibit_hold: got %b expected %b", outs(), 6'b010000);
    else pass_cnt++;
  endtask

  task automatic test_double_write();
    cyc(1, 2'b00, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'd0);
    chk_cnt++;
    if (bus.cnt_clr !== 1'b0) $display("FAIL double_write_early: got %b expected 0", bus.cnt_clr);
    else pass_cnt++;
    cyc(1, 2'b00, 1, 0, 5'd0);
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) cyc(0, 2'b00, 0, 0, 5'd0);
      chk_cnt++;
      if (bus.cnt_clr !== (i == 4)) $display("FAIL double_write cycle %0d: got %b expected %b", i, bus.cnt_clr, i == 4);
      else pass_cnt++;
    end
    cyc(1, 2'b00, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'd0);
    cyc(0, 2'b00, 0, 0, 5'b00010);
    chk_cnt++;
    if (outs() !== 6'b000001) $display("FAIL collision_step1: got %b expected %b", outs(), 6'b000001);
    else pass_cnt++;
    cyc(0, 2'b00, 0, 0, 5'd0);
    chk_cnt++;
    if (outs() !== 6'b000000) $display("FAIL collision_after: got %b expected %b", outs(), 6'b000000);
    else pass_cnt++;
  endtask

  // Model: a pending clear is an absolute deadline cycle; outputs of cycle k+1 follow from inputs of cycle k.
  task automatic test_random();
    bit         m_mode, m_inh, m_irq;
    int         deadline, k, s;
    bit         w, o, r, expiring, eq, eh, ec, set;
    bit [1:0]   d;
    bit [4:0]   st;
    logic [5:0] e;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_mode = 0; m_inh = 0; m_irq = 0; deadline = -1; k = 0;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 7) == 0);
      d = 2'($urandom_range(0, 3));
      o = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        6, 7, 8: st = 5'(1 << $urandom_range(0, 4));
        9:       st = 5'($urandom_range(0, 31));
        default: st = 5'd0;
      endcase
      s = -1;
      for (int b = 4; b >= 0; b--) if (st[b]) s = b;
      expiring = (deadline == k + 1) && !w;
      eq = 0; eh = 0; ec = 0; set = 0;
      if (expiring) begin
        ec = 1; eq = m_mode; eh = m_mode;
      end else begin
        case (s)
          0, 2: eq = 1;
          1: begin eq = 1; eh = 1; end
          3: if (!m_mode) begin eq = 1; eh = 1; ec = 1; set = !m_inh; end
          4: if (m_mode) begin eq = 1; eh = 1; ec = 1; end
          default: ;
        endcase
      end
      if (w && d[0]) m_irq = 0;
      else if (set) m_irq = 1;
      else if (r) m_irq = 0;
      if (w) begin
        m_mode = d[1];
        m_inh = d[0];
        deadline = k + (o ? int'(DLY_O) : int'(DLY_E));
      end else if (expiring) begin
        deadline = -1;
      end
      e = {m_mode, m_inh, eq, eh, m_irq, ec};
      cyc(w, d, o, r, st);
      chk_cnt++;
      if (outs() !== e) $display("FAIL random cycle %0d: got %b expected %b", n, outs(), e);
      else pass_cnt++;
      k++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.wr_4017  = 1'b0;
    bus.din      = 2'b00;
    bus.aclk_odd = 1'b0;
    bus.rd_4015  = 1'b0;
    bus.step_hit = '0;
    test_reset();
    test_write_delay();
    test_mode1();
    test_mode0_irq();
    test_inhibit();
    test_double_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
